async_fifo_wr_gen: RTL and testbench
====================================

ASYNC_FIFO_WR_GEN -- requirements
Module: async_fifo_wr_gen

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data word width; matches FIFO wr_data width.
REQ-002 SHALL have parameter LEN_W, default 5, burst-length field width; max burst 2^LEN_W-1 words.
REQ-003 SHALL have port wr_clk, input, 1, write-domain clock; all state updates on its rising edge.
REQ-004 SHALL have port wr_rstn, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, 1, burst request valid.
REQ-006 SHALL have port req_ready, output, 1, generator can accept a request.
REQ-007 SHALL have port req_len, input, LEN_W, number of words in burst.
REQ-008 SHALL have port req_seed, input, WIDTH, first data word of burst.
REQ-009 SHALL have port abort, input, 1, synchronous burst abort.
REQ-010 SHALL have port full, input, 1, FIFO full flag (write domain).
REQ-011 SHALL have port wr_en, output, 1, FIFO write enable.
REQ-012 SHALL have port wr_data, output, WIDTH, FIFO write data.
REQ-013 SHALL have port busy, output, 1, burst in progress.
REQ-014 SHALL have port done, output, 1, one-cycle burst-complete pulse.
REQ-015 SHALL have port aborted, output, 1, qualifies done: burst ended by abort.

Function
REQ-016 SHALL implement FSM states IDLE, BURST, DONE; req_ready = (state==IDLE); busy = (state==BURST).
REQ-017 IDLE: on req_valid, SHALL latch req_len into remaining and req_seed into data_reg; go BURST if req_len!=0, else go DONE (no writes).
REQ-018 BURST: wr_en SHALL equal !full (combinational); wr_data SHALL equal data_reg; wr_en SHALL be 0 in IDLE and DONE.
REQ-019 Each edge with wr_en=1 SHALL increment data_reg (modulo 2^WIDTH, wrap 0xFF->0x00) and decrement remaining.
REQ-020 Write with remaining==1 SHALL transition BURST->DONE; exactly req_len words written per burst.
REQ-021 full=1 in BURST SHALL stall: no write, data_reg/remaining held, state held; resume the cycle full deasserts.
REQ-022 abort=1 in BURST SHALL go DONE at that edge, aborted set; a write coincident with abort (full=0) SHALL still occur and count.
REQ-023 abort in IDLE or DONE SHALL be ignored; abort and req_valid together in IDLE SHALL accept the request.
REQ-024 DONE: done=1 for exactly one cycle, then IDLE; aborted SHALL be valid with done and cleared on next request acceptance.
REQ-025 Request-to-first-write latency SHALL be 1 cycle (accept edge, wr_en asserted next cycle if !full).
REQ-026 Back-to-back bursts SHALL have a minimum 2-cycle gap (DONE, IDLE) between last and next first write.

Reset
REQ-027 wr_rstn low SHALL asynchronously force state IDLE, remaining=0, data_reg=0, aborted=0; hence wr_en=0, wr_data=0, busy=0, done=0, req_ready=1.
REQ-028 Reset mid-burst SHALL drop the burst with no done pulse; first edge after release is a normal IDLE cycle.

Configuration
REQ-029 Macro WR_GEN_STATS_EN defined: SHALL add outputs word_count[15:0] (total writes) and stall_count[15:0] (BURST cycles with full=1), both saturating at 0xFFFF, reset to 0 by wr_rstn.
REQ-030 Macro WR_GEN_STATS_EN undefined: ports and counters SHALL be absent; all other behaviour identical.

Verification
REQ-031 req_len=4, seed=0x10, full=0 -> wr_en high 4 consecutive cycles, data 0x10..0x13, done one cycle later, aborted=0.
REQ-032 req_len=3, seed=0xFE -> data 0xFE, 0xFF, 0x00 (wrap), done pulse.
REQ-033 req_len=5, full high for 3 cycles after 2nd write -> 5 writes total, no duplicates/skips; stall_count=3 when WR_GEN_STATS_EN.
REQ-034 req_len=8, abort on 3rd write cycle -> 3 words written, done=1 with aborted=1, then req_ready=1.
REQ-035 req_len=0 -> no wr_en, done pulse cycle after accept; wr_rstn pulse mid-burst -> wr_en=0 immediately, no done, req_ready=1.

Source files
------------

// File: rtl/async_fifo_wr_gen.sv
// async_fifo_wr_gen: write-side burst generator for an asynchronous FIFO.
// Accepts a burst request (length + seed), then writes req_len incrementing
// data words into the FIFO, stalling while full is high. A burst may be
// aborted; done pulses once at the end and aborted qualifies it.
//
// Ports:
//   wr_clk, wr_rstn        write-domain clock, async active-low reset
//   req_valid/req_ready    request handshake (ready while idle)
//   req_len, req_seed      burst length and first data word
//   abort                  synchronous burst abort (honoured only in BURST)
//   full                   FIFO full flag, write domain
//   wr_en, wr_data         FIFO write port (wr_en combinational from full)
//   busy, done, aborted    status: burst active, completion pulse, abort flag
//   word_count, stall_count  (only with WR_GEN_STATS_EN) saturating counters
//
// Optional feature macro: WR_GEN_STATS_EN adds the statistics counters.
module async_fifo_wr_gen #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LEN_W = 5
) (
  input  logic             wr_clk,
  input  logic             wr_rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [LEN_W-1:0] req_len,
  input  logic [WIDTH-1:0] req_seed,
  input  logic             abort,
  input  logic             full,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_data,
  output logic             busy,
  output logic             done,
`ifdef WR_GEN_STATS_EN
  output logic [15:0]      word_count,
  output logic [15:0]      stall_count,
`endif
  output logic             aborted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   remaining_q, remaining_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               aborted_q, aborted_d;

  // Status outputs decode directly from the state register.
  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q == BURST);
  assign done      = (state_q == DONE);
  assign aborted   = aborted_q;
  assign wr_data   = data_q;
  // Write enable follows full in the same cycle so a stall costs no extra cycle.
  assign wr_en     = (state_q == BURST) && !full;

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    aborted_d   = aborted_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          remaining_d = req_len;
          data_d      = req_seed;
          aborted_d   = 1'b0;
          state_d     = (req_len != LEN_W'(0)) ? BURST : DONE;
        end
      end
      BURST: begin
        if (wr_en) begin
          data_d      = data_q + WIDTH'(1);
          remaining_d = remaining_q - LEN_W'(1);
          if (remaining_q == LEN_W'(1)) state_d = DONE;
        end
        // Abort wins the state, but a coincident write above still counts.
        if (abort) begin
          state_d   = DONE;
          aborted_d = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      data_q      <= '0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      aborted_q   <= aborted_d;
    end
  end

`ifdef WR_GEN_STATS_EN
  localparam int unsigned CNT_W = 16;

  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating write and stall counters.
  always_comb begin
    word_cnt_d  = word_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (wr_en && (word_cnt_q != '1)) word_cnt_d = word_cnt_q + CNT_W'(1);
    if ((state_q == BURST) && full && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge wr_clk or negedge wr_rstn) begin
    if (!wr_rstn) begin
      word_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      word_cnt_q  <= word_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign word_count  = word_cnt_q;
  assign stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_async_fifo_wr_gen.sv
// Directed self-checking bench for async_fifo_wr_gen (default parameters).
// Inputs change 1 time unit after the rising edge; outputs are sampled on the
// falling edge.
module tb_async_fifo_wr_gen;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned LEN_W = 5;

  logic             wr_clk;
  logic             wr_rstn;
  logic             req_valid;
  logic             req_ready;
  logic [LEN_W-1:0] req_len;
  logic [WIDTH-1:0] req_seed;
  logic             abort;
  logic             full;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic             busy;
  logic             done;
  logic             aborted;
`ifdef WR_GEN_STATS_EN
  logic [15:0]      word_count;
  logic [15:0]      stall_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  async_fifo_wr_gen #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .wr_clk      (wr_clk),
    .wr_rstn     (wr_rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_len     (req_len),
    .req_seed    (req_seed),
    .abort       (abort),
    .full        (full),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .busy        (busy),
    .done        (done),
`ifdef WR_GEN_STATS_EN
    .word_count  (word_count),
    .stall_count (stall_count),
`endif
    .aborted     (aborted)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge wr_clk);
    #1;
  endtask

  // Present a request for one cycle and check it is accepted.
  task automatic accept(input logic [LEN_W-1:0] len, input logic [WIDTH-1:0] seed,
                        input logic ab);
    req_valid = 1'b1;
    req_len   = len;
    req_seed  = seed;
    abort     = ab;
    @(negedge wr_clk);
    check("accept_ready", 32'(req_ready), 32'd1);
    next_cycle();
    req_valid = 1'b0;
    abort     = 1'b0;
  endtask

  task automatic expect_write(input string tag, input logic [WIDTH-1:0] data);
    @(negedge wr_clk);
    check({tag, "_wr_en"}, 32'(wr_en), 32'd1);
    check({tag, "_data"}, 32'(wr_data), 32'(data));
    next_cycle();
  endtask

  task automatic expect_done(input string tag, input logic ab);
    @(negedge wr_clk);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_aborted"}, 32'(aborted), 32'(ab));
    check({tag, "_no_wr"}, 32'(wr_en), 32'd0);
    next_cycle();
    @(negedge wr_clk);
    check({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, "_done_once"}, 32'(done), 32'd0);
  endtask

  initial begin
    req_valid = 1'b0;
    req_len   = '0;
    req_seed  = '0;
    abort     = 1'b0;
    full      = 1'b0;
    wr_rstn   = 1'b1;
    #1 wr_rstn = 1'b0;
    #2;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data", 32'(wr_data), 32'd0);
    check("rst_aborted", 32'(aborted), 32'd0);
    @(negedge wr_clk);
    wr_rstn = 1'b1;
    next_cycle();

    // Plain 4-word burst.
    accept(5'd4, 8'h10, 1'b0);
    for (int i = 0; i < 4; i++) expect_write("b4", 8'h10 + 8'(i));
    expect_done("b4", 1'b0);
    next_cycle();

    // Data wrap across 0xFF.
    accept(5'd3, 8'hFE, 1'b0);
    expect_write("wrap0", 8'hFE);
    expect_write("wrap1", 8'hFF);
    expect_write("wrap2", 8'h00);
    expect_done("wrap", 1'b0);
    next_cycle();

    // Three-cycle stall after the second write.
    accept(5'd5, 8'h20, 1'b0);
    expect_write("st", 8'h20);
    expect_write("st", 8'h21);
    full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge wr_clk);
      check("stall_wr_en", 32'(wr_en), 32'd0);
      check("stall_busy", 32'(busy), 32'd1);
      check("stall_data", 32'(wr_data), 32'h22);
      next_cycle();
    end
    full = 1'b0;
    for (int i = 2; i < 5; i++) expect_write("st", 8'h20 + 8'(i));
    expect_done("st", 1'b0);
`ifdef WR_GEN_STATS_EN
    check("stat_stalls", 32'(stall_count), 32'd3);
    check("stat_words", 32'(word_count), 32'd12);
`endif
    next_cycle();

    // Abort on the third write cycle: that write still lands.
    accept(5'd8, 8'h40, 1'b0);
    expect_write("ab", 8'h40);
    expect_write("ab", 8'h41);
    abort = 1'b1;
    expect_write("ab", 8'h42);
    abort = 1'b0;
    expect_done("ab", 1'b1);
    check("ab_flag_held", 32'(aborted), 32'd1);
    next_cycle();

    // Zero-length request with abort in IDLE: accepted, no writes, aborted cleared.
    accept(5'd0, 8'h55, 1'b1);
    expect_done("zero", 1'b0);
    check("zero_busy", 32'(busy), 32'd0);
    next_cycle();

    // Reset in the middle of a burst.
    accept(5'd5, 8'h70, 1'b0);
    expect_write("rb", 8'h70);
    wr_rstn = 1'b0;
    #1;
    check("rb_wr_en", 32'(wr_en), 32'd0);
    check("rb_busy", 32'(busy), 32'd0);
    check("rb_ready", 32'(req_ready), 32'd1);
    check("rb_data", 32'(wr_data), 32'd0);
    #2 wr_rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge wr_clk);
      check("rb_no_done", 32'(done), 32'd0);
      check("rb_idle", 32'(req_ready), 32'd1);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
